// File: rtl/game_screen_ctl_pkg.sv
// Shared definitions for the Death Race screen sequencer: phase encodings and bus sizing.
`timescale 1ns/1ps
package game_screen_ctl_pkg;

  // Shared VGA bus size: hcount, vcount, syncs, blanks and rgb.
  localparam int unsigned VGA_BUS_W = 38;

  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_COUNT = 2'd1,
    PH_RACE  = 2'd2,
    PH_OVER  = 2'd3
  } phase_e;

  localparam logic [1:0] SEC_INIT = 2'd3;

endpackage

// File: rtl/game_screen_ctl_click_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a rising-edge pulse.
`timescale 1ns/1ps
module click_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic pulse
);

  logic btn_meta_q;
  logic btn_sync_q;
  logic btn_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= btn_async;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign pulse = btn_sync_q & ~btn_prev_q;

endmodule

// File: rtl/game_screen_ctl.sv
// Game phase sequencer: frame-aligned phase FSM, countdown/hold counters and VGA layer mux.
`timescale 1ns/1ps
module game_screen_ctl
  import game_screen_ctl_pkg::*;
#(
  parameter int unsigned BUS_W          = VGA_BUS_W,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned OVER_HOLD      = 120
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             mouse_left,
  input  logic             crash,
  input  logic [BUS_W-1:0] vga_start,
  input  logic [BUS_W-1:0] vga_race,
  input  logic [BUS_W-1:0] vga_over,
  output logic [BUS_W-1:0] vga_out,
  output logic             game_run,
  output logic             game_rst,
  output logic [1:0]       countdown,
  output logic [1:0]       phase
);

  localparam logic [7:0] FrmLast = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] Hold    = 8'(OVER_HOLD);

  logic       click;
  logic       vsync_q;
  logic       tick;
  logic       click_pend;
  logic       crash_pend;
  logic       click_now;
  logic       crash_now;
  logic       start_d;
  phase_e     state_q, state_d;
  logic [1:0] sec_q, sec_d;
  logic [7:0] frm_q, frm_d;
  logic [BUS_W-1:0] bus_sel;

  click_sync u_click_sync (
    .clk       (pclk),
    .rst       (rst),
    .btn_async (mouse_left),
    .pulse     (click)
  );

  assign tick = vsync_in & ~vsync_q;

  // An event arriving on the tick cycle itself still counts for that tick.
  assign click_now = click | click_pend;
  assign crash_now = crash | crash_pend;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      click_pend <= 1'b0;
      crash_pend <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      if (tick) begin
        click_pend <= 1'b0;
        crash_pend <= 1'b0;
      end else begin
        if (click) click_pend <= 1'b1;
        if (crash) crash_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    frm_d   = frm_q;
    start_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        PH_START: begin
          if (click_now) begin
            state_d = PH_COUNT;
            sec_d   = SEC_INIT;
            frm_d   = 8'd0;
            start_d = 1'b1;
          end
        end
        PH_COUNT: begin
          if (frm_q == FrmLast) begin
            frm_d = 8'd0;
            if (sec_q == 2'd1) state_d = PH_RACE;
            else               sec_d   = sec_q - 2'd1;
          end else begin
            frm_d = frm_q + 8'd1;
          end
        end
        PH_RACE: begin
          if (crash_now) begin
            state_d = PH_OVER;
            frm_d   = 8'd0;
          end
        end
        PH_OVER: begin
          if (frm_q >= Hold && click_now) begin
            state_d = PH_START;
          end else if (frm_q < Hold) begin
            frm_d = frm_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The mux follows the post-tick state so the new layer appears right after the tick.
  always_comb begin
    bus_sel = '0;
    unique case (state_d)
      PH_START:          bus_sel = vga_start;
      PH_COUNT, PH_RACE: bus_sel = vga_race;
      PH_OVER:           bus_sel = vga_over;
      default:           bus_sel = '0;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= PH_START;
      sec_q     <= 2'd0;
      frm_q     <= 8'd0;
      game_run  <= 1'b0;
      game_rst  <= 1'b0;
      countdown <= 2'd0;
      vga_out   <= '0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      frm_q     <= frm_d;
      game_run  <= (state_d == PH_RACE);
      game_rst  <= start_d;
      countdown <= (state_d == PH_COUNT) ? sec_d : 2'd0;
      vga_out   <= bus_sel;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_game_screen_ctl.sv
// Randomized bench for game_screen_ctl against a tick-counting phase model.
`timescale 1ns/1ps
module tb_game_screen_ctl;
  import game_screen_ctl_pkg::*;

  localparam int unsigned BW    = VGA_BUS_W;
  localparam int unsigned FPS   = 4;
  localparam int unsigned HOLD  = 5;
  localparam int          FRAME = 16;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_in = 1'b0;
  logic          mouse_left = 1'b0;
  logic          crash = 1'b0;
  logic [BW-1:0] vga_start = '0;
  logic [BW-1:0] vga_race = '0;
  logic [BW-1:0] vga_over = '0;
  logic [BW-1:0] vga_out;
  logic          game_run;
  logic          game_rst;
  logic [1:0]    countdown;
  logic [1:0]    phase;

  int tests = 0;
  int fails = 0;
  int fpos  = FRAME - 1;

  game_screen_ctl #(
    .BUS_W          (BW),
    .FRAMES_PER_SEC (FPS),
    .OVER_HOLD      (HOLD)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .mouse_left (mouse_left),
    .crash      (crash),
    .vga_start  (vga_start),
    .vga_race   (vga_race),
    .vga_over   (vga_over),
    .vga_out    (vga_out),
    .game_run   (game_run),
    .game_rst   (game_rst),
    .countdown  (countdown),
    .phase      (phase)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame timing and random layer buses.
  initial begin
    forever begin
      @(negedge pclk);
      fpos      = (fpos + 1) % FRAME;
      vsync_in  = (fpos < 2);
      vga_start = BW'({$urandom(), $urandom()});
      vga_race  = BW'({$urandom(), $urandom()});
      vga_over  = BW'({$urandom(), $urandom()});
    end
  end

  // Reference model: phase plus number of frame ticks spent in it.
  event          tick_ev;
  int            m_ph = 0;
  int            n_ticks = 0;
  logic          click_seen = 1'b0;
  logic          crash_seen = 1'b0;
  logic [2:0]    mh = '0;
  logic          vs_prev = 1'b0;
  logic          click_now, tick_now, cl, cr;
  logic [BW-1:0] e_vga = '0;
  logic          e_run = 1'b0;
  logic          e_rst = 1'b0;
  logic [1:0]    e_cd = '0;
  logic [1:0]    e_ph = '0;

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_ph = 0; n_ticks = 0; click_seen = 0; crash_seen = 0; mh = '0; vs_prev = 0;
      e_vga = '0; e_run = 0; e_rst = 0; e_cd = '0; e_ph = '0;
    end else begin
      // Button seen two edges late, pulse on its rise; mh[0] is the newest sample.
      click_now = mh[1] & ~mh[2];
      tick_now  = vsync_in & ~vs_prev;
      cl = click_seen | click_now;
      cr = crash_seen | crash;
      e_rst = 1'b0;
      if (tick_now) begin
        n_ticks++;
        case (m_ph)
          0: if (cl) begin m_ph = 1; n_ticks = 0; e_rst = 1'b1; end
          1: if (n_ticks == 3 * FPS) begin m_ph = 2; n_ticks = 0; end
          2: if (cr) begin m_ph = 3; n_ticks = 0; end
          default: if (cl && n_ticks > HOLD) begin m_ph = 0; n_ticks = 0; end
        endcase
        click_seen = 1'b0;
        crash_seen = 1'b0;
      end else begin
        click_seen = cl;
        crash_seen = cr;
      end
      e_ph  = 2'(m_ph);
      e_run = (m_ph == 2);
      e_cd  = (m_ph == 1) ? 2'(3 - n_ticks / FPS) : 2'd0;
      e_vga = (m_ph == 0) ? vga_start : (m_ph == 3) ? vga_over : vga_race;
      mh      = {mh[1:0], mouse_left};
      vs_prev = vsync_in;
      if (tick_now) ->tick_ev;
    end
  end

  always @(negedge pclk) begin
    check("vga_out", 64'(vga_out), 64'(e_vga));
    check("phase", 64'(phase), 64'(e_ph));
    check("game_run", 64'(game_run), 64'(e_run));
    check("game_rst", 64'(game_rst), 64'(e_rst));
    check("countdown", 64'(countdown), 64'(e_cd));
  end

  task automatic wait_ticks(input int k);
    repeat (k) @(tick_ev);
    @(negedge pclk);
  endtask

  task automatic click_mid(input int delay);
    repeat (delay) @(negedge pclk);
    mouse_left = 1'b1;
    repeat (3) @(negedge pclk);
    mouse_left = 1'b0;
  endtask

  logic [1:0] cd_exp [12];

  initial begin
    for (int j = 0; j < 12; j++) cd_exp[j] = 2'(3 - j / 4);
    repeat (3) @(negedge pclk);
    rst = 1'b0;

    wait_ticks(2);
    check("idle_phase", 64'(phase), 64'(0));
    check("idle_run", 64'(game_run), 64'(0));

    click_mid(4);
    wait_ticks(1);
    check("start_phase", 64'(phase), 64'(1));
    check("start_rst", 64'(game_rst), 64'(1));
    check("cd_tick0", 64'(countdown), 64'(3));
    @(negedge pclk);
    check("start_rst_1cyc", 64'(game_rst), 64'(0));
    for (int j = 1; j < 12; j++) begin
      wait_ticks(1);
      check("cd_seq", 64'(countdown), 64'(cd_exp[j]));
    end
    wait_ticks(1);
    check("race_phase", 64'(phase), 64'(2));
    check("race_run", 64'(game_run), 64'(1));
    check("race_cd", 64'(countdown), 64'(0));

    // Crash and click in the same race frame.
    wait_ticks(1);
    repeat (3) @(negedge pclk);
    mouse_left = 1'b1;
    crash = 1'b1;
    @(negedge pclk);
    crash = 1'b0;
    repeat (3) @(negedge pclk);
    mouse_left = 1'b0;
    wait_ticks(1);
    check("over_phase", 64'(phase), 64'(3));
    check("over_run", 64'(game_run), 64'(0));

    // Now in OVER frame 0; click in frame 2 is too early.
    wait_ticks(2);
    click_mid(3);
    wait_ticks(1);
    check("hold_early", 64'(phase), 64'(3));
    wait_ticks(1);
    check("hold_discard", 64'(phase), 64'(3));
    wait_ticks(2);
    click_mid(3);
    wait_ticks(1);
    check("hold_done", 64'(phase), 64'(0));

    // New game, then reset mid-race mid-line.
    click_mid(4);
    wait_ticks(1 + 3 * FPS + 1);
    check("race2_phase", 64'(phase), 64'(2));
    repeat (5) @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    check("rst_phase", 64'(phase), 64'(0));
    check("rst_vga", 64'(vga_out), 64'(0));
    check("rst_run", 64'(game_run), 64'(0));
    check("rst_cd", 64'(countdown), 64'(0));
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    check("post_rst_phase", 64'(phase), 64'(0));

    // Random clicks, crashes and one asynchronous reset, checked every cycle.
    for (int c = 0; c < FRAME * 300; c++) begin
      @(negedge pclk);
      if ($urandom_range(0, 19) == 0) mouse_left = ~mouse_left;
      crash = ($urandom_range(0, 39) == 0);
      if (c == 2000) rst = 1'b1;
      if (c == 2003) rst = 1'b0;
    end
    crash = 1'b0;
    mouse_left = 1'b0;
    @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
